// File: rtl/fp32_div_ctrl_pkg.sv
// Shared types and constants for the FP32 divide controller.
// State encoding, special values, flag indices, operand classifier.
package fp32_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    FC_ZERO,
    FC_SUB,
    FC_NORM,
    FC_INF,
    FC_NAN
  } fp_class_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  function automatic fp_class_e fp_class(
    input logic [31:0] x
  );
    fp_class_e c;
    logic e_max;
    logic e_min;
    logic m_z;
    e_max = (x[30:23] == 8'hFF);
    e_min = (x[30:23] == 8'h00);
    m_z   = (x[22:0] == 23'd0);
    unique case (1'b1)
      e_max && !m_z: c = FC_NAN;
      e_max &&  m_z: c = FC_INF;
      e_min &&  m_z: c = FC_ZERO;
      e_min && !m_z: c = FC_SUB;
      default:       c = FC_NORM;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fp32_div_ctrl_if.sv
// Operand/result valid-ready bundle for the FP32 divide controller.
// master: producer/consumer side; slave: the controller.
interface fp32_div_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [4:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q, out_flags
  );
endinterface

// File: rtl/fp32_div_ctrl_special.sv
// IEEE special-case decode for a/b: i_a, i_b in;
// o_special, o_q (packed result), o_flags {NV,DZ,OF,UF,NX} out.
module fp32_div_special
  import fp32_div_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_special,
  output logic [31:0] o_q,
  output logic [4:0]  o_flags
);

  fp_class_e w_ca;
  fp_class_e w_cb;
  logic      w_s;
  logic      w_nan;
  logic      w_za;
  logic      w_zb;
  logic      w_ia;
  logic      w_ib;

  assign w_ca  = fp_class(i_a);
  assign w_cb  = fp_class(i_b);
  assign w_s   = i_a[31] ^ i_b[31];
  assign w_nan = (w_ca == FC_NAN) || (w_cb == FC_NAN);
  assign w_za  = (w_ca == FC_ZERO);
  assign w_zb  = (w_cb == FC_ZERO);
  assign w_ia  = (w_ca == FC_INF);
  assign w_ib  = (w_cb == FC_INF);

  // Priority order matters: inf/0 must land on the inf rule, not DZ.
  always_comb begin
    o_special = 1'b1;
    o_q       = 32'd0;
    o_flags   = 5'd0;
    if (w_nan || (w_za && w_zb) || (w_ia && w_ib)) begin
      o_q            = QNAN;
      o_flags[FL_NV] = 1'b1;
    end else if (w_zb && !w_ia) begin
      o_q            = {w_s, PINF[30:0]};
      o_flags[FL_DZ] = 1'b1;
    end else if (w_ia) begin
      o_q = {w_s, PINF[30:0]};
    end else if (w_za || w_ib) begin
      o_q = {w_s, 31'd0};
    end else begin
      o_special = 1'b0;
    end
  end

endmodule

// File: rtl/fp32_div_ctrl.sv
// Sequencer for the radix-4 SRT FP32 divider core.
// Ports: clk, rst (async, low), bus (operands/result), flush, busy, core_*.
module fp32_div_ctrl
  import fp32_div_pkg::*;
#(
  parameter int ITERS = 13,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fp32_div_ctrl_if.slave       bus,
  input  logic                 flush,
  output logic                 busy,
  output logic                 core_load,
  output logic                 core_en,
  output logic [31:0]          core_a,
  output logic [31:0]          core_b,
  input  logic [31:0]          core_q,
  input  logic [2:0]           core_flags
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_load;
  logic             r_en;
  logic             r_oval;
  logic [31:0]      r_q;
  logic [4:0]       r_flags;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             w_special;
  logic [31:0]      w_sq;
  logic [4:0]       w_sflags;
  logic             w_acc;

  fp32_div_special u_special (
    .i_a       (bus.in_a),
    .i_b       (bus.in_b),
    .o_special (w_special),
    .o_q       (w_sq),
    .o_flags   (w_sflags)
  );

  assign w_acc = (r_state == S_IDLE) && bus.in_valid && !flush;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.in_valid)
          w_next = w_special ? S_DONE : S_LOAD;
      S_LOAD:
        w_next = S_ITER;
      S_ITER:
        if (r_cnt == CNT_W'(ITERS - 1))
          w_next = S_ROUND;
      S_ROUND:
        w_next = S_DONE;
      S_DONE:
        if (bus.out_ready)
          w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
    if (flush)
      w_next = S_IDLE;
  end

  // Strobes are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_en    <= 1'b0;
      r_oval  <= 1'b0;
      r_q     <= 32'd0;
      r_flags <= 5'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
    end else begin
      r_state <= w_next;
      r_load  <= (w_next == S_LOAD);
      r_en    <= (w_next == S_ITER);
      r_oval  <= (w_next == S_DONE);
      if (flush || r_state == S_LOAD)
        r_cnt <= '0;
      else if (r_state == S_ITER)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_acc) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
        if (w_special) begin
          r_q     <= w_sq;
          r_flags <= w_sflags;
        end
      end
      if (r_state == S_ROUND && !flush) begin
        r_q     <= core_q;
        r_flags <= {2'b00, core_flags};
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign bus.out_valid = r_oval;
  assign bus.out_q     = r_q;
  assign bus.out_flags = r_flags;
  assign core_load     = r_load;
  assign core_en       = r_en;
  assign core_a        = r_a;
  assign core_b        = r_b;

endmodule
